// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 engine memory arbiter.
// Holds the memory port widths and the arbiter state encoding.
package sha256_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sha256_rr_pick.sv
// Combinational round-robin picker.
// Scans req upward starting one past ptr (wrapping) and returns the first
// set request as a one-hot vector; any flags that at least one req is set.
module sha256_rr_pick
  import sha256_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // First set request after ptr, in wrap-around order.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pick    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        pick[w_idx] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sha256_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ hash
// engines. A granted engine keeps the port for as long as it holds req; on
// release the port goes idle for one cycle and the releasing engine becomes
// lowest priority. Reads return one cycle later, flagged by rdata_valid.
// Optional feature: define SHA_ARB_TIMEOUT_EN to bound every tenure to
// MAX_HOLD granted cycles, with a one-cycle timeout pulse on forced release.
module sha256_mem_arbiter
  import sha256_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rdata_valid,
  output logic [DATA_W-1:0]               rdata,
  output logic                            memory_clk,
  output logic [ADDR_W-1:0]               memory_addr,
  output logic [DATA_W-1:0]               memory_write_data,
  output logic                            enable_write,
  input  logic [DATA_W-1:0]               memory_read_data,
  output logic                            timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time guard on the supported parameter range.
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (MAX_HOLD < 1)) begin : g_bad_params
    $error("sha256_mem_arbiter: NUM_REQ must be 2..8 and MAX_HOLD >= 1");
  end

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0] r_rdata_valid, w_rdata_valid_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] w_pick;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_any;
  logic               w_own_req;
  logic               w_qual;
  logic               w_release;
  logic               w_hold_expire;

  sha256_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req  (req),
    .ptr  (r_rr_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  // Encode the one-hot pick into the owner index stored on grant.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
  end

  // The port is driven only while the owner still holds its request;
  // gnt is nonzero exactly when an owner exists.
  assign w_own_req = req[r_owner];
  assign w_qual    = (|r_gnt) && w_own_req;
  assign w_release = (r_state == OWNED) && (!w_own_req || w_hold_expire);

  assign memory_clk        = clk;
  assign memory_addr       = w_qual ? req_addr[r_owner]  : '0;
  assign memory_write_data = w_qual ? req_wdata[r_owner] : '0;
  assign enable_write      = w_qual & req_we[r_owner];
  assign rdata             = memory_read_data;
  assign gnt               = r_gnt;
  assign rdata_valid       = r_rdata_valid;

  // Next-state, next-grant and read-valid logic for the two-state FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_nxt         = r_gnt;
    w_owner_nxt       = r_owner;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_rdata_valid_nxt = '0;

    if (w_qual && !req_we[r_owner]) begin
      w_rdata_valid_nxt[r_owner] = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = OWNED;
          w_gnt_nxt   = w_pick;
          w_owner_nxt = w_pick_idx;
        end
      end
      OWNED: begin
        if (w_release) begin
          w_state_nxt  = IDLE;
          w_gnt_nxt    = '0;
          w_rr_ptr_nxt = r_owner;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State, grant and read-valid registers; reset hands engine 0 first grant.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state       <= IDLE;
      r_gnt         <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= PTR_W'(NUM_REQ - 1);
      r_rdata_valid <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt         <= w_gnt_nxt;
      r_owner       <= w_owner_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
    end
  end

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_timeout;

  // The MAX_HOLD-th granted cycle is the last one of the tenure.
  assign w_hold_expire = (r_state == OWNED) &&
                         (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Count granted cycles; flag a release forced while req was still high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_hold_expire && w_own_req;
      if ((r_state == OWNED) && !w_release) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_hold_expire = 1'b0;
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Directed self-checking bench for sha256_mem_arbiter: a per-cycle vector
// table for reset and round-robin rotation, then hand-written sequences for
// writes, read-after-release, reset mid-tenure and (when compiled in) the
// SHA_ARB_TIMEOUT_EN forced release.
module tb_sha256_mem_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_HOLD = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0]            req;
  logic [3:0]            req_we;
  logic [3:0][15:0]      req_addr;
  logic [3:0][31:0]      req_wdata;
  logic [3:0]            gnt;
  logic [3:0]            rdata_valid;
  logic [31:0]           rdata;
  logic                  memory_clk;
  logic [15:0]           memory_addr;
  logic [31:0]           memory_write_data;
  logic                  enable_write;
  logic [31:0]           memory_read_data;
  logic                  timeout;

  int n_tests = 0;
  int n_fail  = 0;

  sha256_mem_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .gnt               (gnt),
    .rdata_valid       (rdata_valid),
    .rdata             (rdata),
    .memory_clk        (memory_clk),
    .memory_addr       (memory_addr),
    .memory_write_data (memory_write_data),
    .enable_write      (enable_write),
    .memory_read_data  (memory_read_data),
    .timeout           (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [3:0] we;
    logic [3:0] exp_gnt;
    logic       exp_q;    // owner's request is live this cycle
    logic [3:0] exp_rv;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    idx_of = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx_of = 2'(i);
    end
  endfunction

  function automatic void add(input string n, input logic r, input logic [3:0] rq,
                              input logic [3:0] we, input logic [3:0] eg,
                              input logic eq, input logic [3:0] erv);
    vec_t v;
    v.name = n; v.rst = r; v.req = rq; v.we = we;
    v.exp_gnt = eg; v.exp_q = eq; v.exp_rv = erv;
    tbl.push_back(v);
  endfunction

  // Drive one cycle of inputs at the falling edge, then check all outputs.
  task automatic step(input string name, input logic r, input logic [3:0] rq,
                      input logic [3:0] we, input logic [3:0] eg, input logic eq,
                      input logic [3:0] erv, input logic eto);
    logic [1:0]  k;
    logic [15:0] ea;
    logic [31:0] ed;
    logic        ee;
    @(negedge clk);
    rst    = r;
    req    = rq;
    req_we = we;
    #1;
    k  = idx_of(eg);
    ea = eq ? req_addr[k]  : 16'h0;
    ed = eq ? req_wdata[k] : 32'h0;
    ee = eq & we[k];
    check({name, ".gnt"},         32'(gnt),               32'(eg));
    check({name, ".rdata_valid"}, 32'(rdata_valid),       32'(erv));
    check({name, ".timeout"},     32'(timeout),           32'(eto));
    check({name, ".addr"},        32'(memory_addr),       32'(ea));
    check({name, ".wdata"},       memory_write_data,      ed);
    check({name, ".we"},          32'(enable_write),      32'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    req              = 4'b0000;
    req_we           = 4'b0000;
    req_addr[0]      = 16'h0100;
    req_addr[1]      = 16'h0020;
    req_addr[2]      = 16'h0010;
    req_addr[3]      = 16'h0300;
    req_wdata[0]     = 32'h1111_0000;
    req_wdata[1]     = 32'hDEAD_BEEF;
    req_wdata[2]     = 32'h3333_0002;
    req_wdata[3]     = 32'h4444_0003;
    memory_read_data = 32'hC0DE_0010;

    // Single requester, then reset, then all four requesting with each owner
    // dropping req for one cycle after three granted cycles.
    add("a_idle", 0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000);
    add("a_gnt0", 0, 4'b0001, 4'b0000, 4'b0001, 1, 4'b0000);
    add("a_hold", 0, 4'b0001, 4'b0000, 4'b0001, 1, 4'b0001);
    add("a_drop", 0, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0001);
    add("a_rel",  0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
    add("rst",    1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
    add("b_idle", 0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000);
    add("b_o0_1", 0, 4'b1111, 4'b0000, 4'b0001, 1, 4'b0000);
    add("b_o0_2", 0, 4'b1111, 4'b0000, 4'b0001, 1, 4'b0001);
    add("b_o0_3", 0, 4'b1111, 4'b0000, 4'b0001, 1, 4'b0001);
    add("b_o0_d", 0, 4'b1110, 4'b0000, 4'b0001, 0, 4'b0001);
    add("b_gap0", 0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000);
    add("b_o1_1", 0, 4'b1111, 4'b0000, 4'b0010, 1, 4'b0000);
    add("b_o1_2", 0, 4'b1111, 4'b0000, 4'b0010, 1, 4'b0010);
    add("b_o1_3", 0, 4'b1111, 4'b0000, 4'b0010, 1, 4'b0010);
    add("b_o1_d", 0, 4'b1101, 4'b0000, 4'b0010, 0, 4'b0010);
    add("b_gap1", 0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000);
    add("b_o2_1", 0, 4'b1111, 4'b0000, 4'b0100, 1, 4'b0000);
    add("b_o2_2", 0, 4'b1111, 4'b0000, 4'b0100, 1, 4'b0100);
    add("b_o2_3", 0, 4'b1111, 4'b0000, 4'b0100, 1, 4'b0100);
    add("b_o2_d", 0, 4'b1011, 4'b0000, 4'b0100, 0, 4'b0100);
    add("b_gap2", 0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000);
    add("b_o3_1", 0, 4'b1111, 4'b0000, 4'b1000, 1, 4'b0000);
    add("b_o3_2", 0, 4'b1111, 4'b0000, 4'b1000, 1, 4'b1000);
    add("b_o3_3", 0, 4'b1111, 4'b0000, 4'b1000, 1, 4'b1000);
    add("b_o3_d", 0, 4'b0111, 4'b0000, 4'b1000, 0, 4'b1000);
    add("b_gap3", 0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000);
    add("b_o0_w", 0, 4'b1111, 4'b0000, 4'b0001, 1, 4'b0000);
    add("b_o0_e", 0, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0001);
    add("b_end",  0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);

    repeat (3) @(posedge clk);
    step("reset", 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    check("memory_clk_low", 32'(memory_clk), 32'd0);
    @(posedge clk);
    #1;
    check("memory_clk_high", 32'(memory_clk), 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].name, tbl[i].rst, tbl[i].req, tbl[i].we,
           tbl[i].exp_gnt, tbl[i].exp_q, tbl[i].exp_rv, 1'b0);
    end

    // Owner 1 writes once; a write strobe without req must not reach memory.
    step("w_idle",  0, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    step("w_wr",    0, 4'b0010, 4'b0010, 4'b0010, 1, 4'b0000, 0);
    check("w_wr.addr_0020",  32'(memory_addr), 32'h0000_0020);
    check("w_wr.data_beef",  memory_write_data, 32'hDEAD_BEEF);
    check("w_wr.we_high",    32'(enable_write), 32'd1);
    step("w_rd",    0, 4'b0010, 4'b0000, 4'b0010, 1, 4'b0000, 0);
    step("w_noreq", 0, 4'b0000, 4'b0010, 4'b0010, 0, 4'b0010, 0);
    step("w_rel",   0, 4'b0000, 4'b0010, 4'b0000, 0, 4'b0000, 0);

    // Owner 2 reads 0x0010, then drops req; the read still reports valid.
    step("r_idle",  0, 4'b0100, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    step("r_rd",    0, 4'b0100, 4'b0000, 4'b0100, 1, 4'b0000, 0);
    check("r_rd.addr_0010", 32'(memory_addr), 32'h0000_0010);
    check("r_rd.rdata",     rdata, 32'hC0DE_0010);
    step("r_drop",  0, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0100, 0);
    step("r_rel",   0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);

    // Reset lands while owner 1 is mid-burst with a read pending.
    step("x_idle",  0, 4'b0010, 4'b0010, 4'b0000, 0, 4'b0000, 0);
    step("x_wr",    0, 4'b0010, 4'b0010, 4'b0010, 1, 4'b0000, 0);
    step("x_rst",   1, 4'b0010, 4'b0000, 4'b0010, 1, 4'b0000, 0);
    step("x_after", 0, 4'b0011, 4'b0010, 4'b0000, 0, 4'b0000, 0);
    step("x_gnt0",  0, 4'b0001, 4'b0000, 4'b0001, 1, 4'b0000, 0);
    step("x_drop",  0, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 0);
    step("x_rel",   0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);

`ifdef SHA_ARB_TIMEOUT_EN
    // Owner 0 keeps req high; engine 3 waits and takes over after the cap.
    step("t_rst",   1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    step("t_idle",  0, 4'b1001, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    for (int c = 1; c <= MAX_HOLD; c++) begin
      step($sformatf("t_hold%0d", c), 0, 4'b1001, 4'b0000, 4'b0001, 1,
           (c == 1) ? 4'b0000 : 4'b0001, 0);
    end
    step("t_force", 0, 4'b1001, 4'b0000, 4'b0000, 0, 4'b0001, 1);
    step("t_gnt3",  0, 4'b1001, 4'b0000, 4'b1000, 1, 4'b0000, 0);
    step("t_drop",  0, 4'b0000, 4'b0000, 4'b1000, 0, 4'b1000, 0);
    step("t_rel",   0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
